// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults and types for the multi-port register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_DATA_W_DEF = 32;
    localparam int c_ADDR_W_DEF = 5;

    typedef logic [c_ADDR_W_DEF-1:0] regAddr_t;

    // Address of the hard-wired zero register when that feature is enabled
    localparam regAddr_t c_ZERO_ADDR = '0;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy bits with set/clear/flush priority and
//                combinational hazard lookup for the two read addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_issEn,
    input  logic [ADDR_W-1:0] i_issAddr,
    input  logic              i_flush,
    input  logic              i_wrEn0,
    input  logic [ADDR_W-1:0] i_wrAddr0,
    input  logic              i_wrEn1,
    input  logic [ADDR_W-1:0] i_wrAddr1,
    input  logic [ADDR_W-1:0] i_rdAddrA,
    input  logic [ADDR_W-1:0] i_rdAddrB,
    output logic              o_busyA,
    output logic              o_busyB
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [c_DEPTH-1:0] r_busy;
    logic [c_DEPTH-1:0] w_busyNext;
    logic               w_fwdA;
    logic               w_fwdB;

    // Next busy vector: writes clear, issue sets (new producer wins), flush clears all
    always_comb begin
        w_busyNext = r_busy;
        if (i_wrEn0) w_busyNext[i_wrAddr0] = 1'b0;
        if (i_wrEn1) w_busyNext[i_wrAddr1] = 1'b0;
        if (i_issEn) w_busyNext[i_issAddr] = 1'b1;
        if (ZERO_REG) w_busyNext[c_ZERO_ADDR[0 +: 1] == 1'b0 ? 0 : 0] = 1'b0;
        if (i_flush) w_busyNext = '0;
    end

    // Busy vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busyNext;
    end

    // A write landing this cycle is forwarded by the read path, so it is no hazard.
    // With the zero register enabled busy[0] is never set, so address 0 reads not busy.
    always_comb begin
        w_fwdA  = (i_wrEn0 && (i_wrAddr0 == i_rdAddrA)) || (i_wrEn1 && (i_wrAddr1 == i_rdAddrA));
        w_fwdB  = (i_wrEn0 && (i_wrAddr0 == i_rdAddrB)) || (i_wrEn1 && (i_wrAddr1 == i_rdAddrB));
        o_busyA = r_busy[i_rdAddrA] & ~w_fwdA;
        o_busyB = r_busy[i_rdAddrB] & ~w_fwdB;
    end

endmodule
`default_nettype wire

// File: rtl/register_bank_mp.sv
`default_nettype none
// ============================================================================
//  Module      : register_bank_mp
//  Description : Multi-port CPU register file: two registered read ports with
//                write bypass, two prioritised write ports (port 1 wins) and a
//                busy scoreboard for the stall logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_bank_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W_DEF,
    parameter int ADDR_W   = c_ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en_0,
    input  logic [ADDR_W-1:0] wr_addr_0,
    input  logic [DATA_W-1:0] wr_data_0,
    input  logic              wr_en_1,
    input  logic [ADDR_W-1:0] wr_addr_1,
    input  logic [DATA_W-1:0] wr_data_1,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              flush
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(c_ZERO_ADDR);

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic [DATA_W-1:0] r_rdDataA;
    logic [DATA_W-1:0] r_rdDataB;
    logic              r_rdValid;
    logic [DATA_W-1:0] w_rdNextA;
    logic [DATA_W-1:0] w_rdNextB;
    logic              w_zeroA;
    logic              w_zeroB;

    // Storage array; port 1 overrides port 0 on an address clash, register 0 may be pinned to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < c_DEPTH; i++) begin
                if (!(ZERO_REG && (i == 0))) begin
                    if (wr_en_1 && (wr_addr_1 == ADDR_W'(i)))      r_mem[i] <= wr_data_1;
                    else if (wr_en_0 && (wr_addr_0 == ADDR_W'(i))) r_mem[i] <= wr_data_0;
                end
            end
        end
    end

    // Read muxes with same-cycle write bypass, same priority as the array write
    always_comb begin
        w_zeroA   = ZERO_REG && (rd_addr_a == c_ZERO);
        w_zeroB   = ZERO_REG && (rd_addr_b == c_ZERO);
        w_rdNextA = r_mem[rd_addr_a];
        w_rdNextB = r_mem[rd_addr_b];
        if (wr_en_0 && (wr_addr_0 == rd_addr_a)) w_rdNextA = wr_data_0;
        if (wr_en_1 && (wr_addr_1 == rd_addr_a)) w_rdNextA = wr_data_1;
        if (wr_en_0 && (wr_addr_0 == rd_addr_b)) w_rdNextB = wr_data_0;
        if (wr_en_1 && (wr_addr_1 == rd_addr_b)) w_rdNextB = wr_data_1;
        if (w_zeroA) w_rdNextA = '0;
        if (w_zeroB) w_rdNextB = '0;
    end

    // Read output registers; data holds when no read is requested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdDataA <= '0;
            r_rdDataB <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= rd_en;
            if (rd_en) begin
                r_rdDataA <= w_rdNextA;
                r_rdDataB <= w_rdNextB;
            end
        end
    end

    assign rd_data_a = r_rdDataA;
    assign rd_data_b = r_rdDataB;
    assign rd_valid  = r_rdValid;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_issEn   (iss_en),
        .i_issAddr (iss_addr),
        .i_flush   (flush),
        .i_wrEn0   (wr_en_0),
        .i_wrAddr0 (wr_addr_0),
        .i_wrEn1   (wr_en_1),
        .i_wrAddr1 (wr_addr_1),
        .i_rdAddrA (rd_addr_a),
        .i_rdAddrB (rd_addr_b),
        .o_busyA   (busy_a),
        .o_busyB   (busy_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_bank_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_bank_mp
//  Description : Self-checking bench for register_bank_mp against a simple
//                array-based reference model of the register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_bank_mp;

    logic        clk;
    logic        rst_n;
    logic        rd_en;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        rd_valid;
    logic        busy_a;
    logic        busy_b;
    logic        wr_en_0;
    logic [4:0]  wr_addr_0;
    logic [31:0] wr_data_0;
    logic        wr_en_1;
    logic [4:0]  wr_addr_1;
    logic [31:0] wr_data_1;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;

    int checkCnt = 0;
    int failCnt  = 0;

    // Reference model: architectural register contents and busy flags
    logic [31:0] mdlReg  [32];
    bit          mdlBusy [32];
    logic [31:0] expA;
    logic [31:0] expB;
    logic        expValid;

    register_bank_mp #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .ZERO_REG (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .wr_en_0   (wr_en_0),
        .wr_addr_0 (wr_addr_0),
        .wr_data_0 (wr_data_0),
        .wr_en_1   (wr_en_1),
        .wr_addr_1 (wr_addr_1),
        .wr_data_1 (wr_data_1),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            failCnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic setIdle();
        rd_en = 0; rd_addr_a = 0; rd_addr_b = 0;
        wr_en_0 = 0; wr_addr_0 = 0; wr_data_0 = 0;
        wr_en_1 = 0; wr_addr_1 = 0; wr_data_1 = 0;
        iss_en = 0; iss_addr = 0; flush = 0;
    endtask

    task automatic resetModel();
        for (int i = 0; i < 32; i++) begin
            mdlReg[i]  = '0;
            mdlBusy[i] = 1'b0;
        end
        expA = '0; expB = '0; expValid = 1'b0;
    endtask

    // Hazard as the stall logic should see it: pending producer not satisfied by a write this cycle
    function automatic logic expBusy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (wr_en_0 && wr_addr_0 == a) return 1'b0;
        if (wr_en_1 && wr_addr_1 == a) return 1'b0;
        return mdlBusy[a];
    endfunction

    // Called just after a falling edge with inputs driven; ends at the next falling edge
    task automatic stepCycle();
        #1;
        checkVal("busy_a", 32'(busy_a), 32'(expBusy(rd_addr_a)));
        checkVal("busy_b", 32'(busy_b), 32'(expBusy(rd_addr_b)));
        // Apply writes in priority order: the later (port 1) store wins
        if (wr_en_0 && wr_addr_0 != 0) mdlReg[wr_addr_0] = wr_data_0;
        if (wr_en_1 && wr_addr_1 != 0) mdlReg[wr_addr_1] = wr_data_1;
        if (wr_en_0) mdlBusy[wr_addr_0] = 1'b0;
        if (wr_en_1) mdlBusy[wr_addr_1] = 1'b0;
        if (iss_en && iss_addr != 0) mdlBusy[iss_addr] = 1'b1;
        if (flush) for (int i = 0; i < 32; i++) mdlBusy[i] = 1'b0;
        // A read returns the register value as it stands after this cycle's writes
        if (rd_en) begin
            expA = mdlReg[rd_addr_a];
            expB = mdlReg[rd_addr_b];
        end
        expValid = rd_en;
        @(posedge clk);
        #1;
        checkVal("rd_data_a", rd_data_a, expA);
        checkVal("rd_data_b", rd_data_b, expB);
        checkVal("rd_valid", 32'(rd_valid), 32'(expValid));
        @(negedge clk);
    endtask

    function automatic logic [4:0] randAddr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        setIdle();
        resetModel();
        rst_n = 1'b0;
        #3;
        checkVal("reset_rd_data_a", rd_data_a, 32'h0);
        checkVal("reset_rd_valid", 32'(rd_valid), 32'h0);
        checkVal("reset_busy_a", 32'(busy_a), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read, with port B on the zero register
        setIdle(); wr_en_0 = 1; wr_addr_0 = 5; wr_data_0 = 32'h12345678;
        stepCycle();
        setIdle(); rd_en = 1; rd_addr_a = 5; rd_addr_b = 0;
        stepCycle();
        checkVal("wr_rd_a", rd_data_a, 32'h12345678);
        checkVal("wr_rd_b", rd_data_b, 32'h0);

        // Port clash: port 1 data is stored
        setIdle(); wr_en_0 = 1; wr_addr_0 = 7; wr_data_0 = 32'hABCDEF01;
        wr_en_1 = 1; wr_addr_1 = 7; wr_data_1 = 32'h87654321;
        stepCycle();
        setIdle(); rd_en = 1; rd_addr_a = 7;
        stepCycle();
        checkVal("clash_rd", rd_data_a, 32'h87654321);

        // Same-cycle bypass
        setIdle(); rd_en = 1; rd_addr_a = 9; wr_en_1 = 1; wr_addr_1 = 9; wr_data_1 = 32'h55555555;
        stepCycle();
        checkVal("bypass_rd", rd_data_a, 32'h55555555);

        // Scoreboard set, forwarded clear, issue-wins on a collision
        setIdle(); iss_en = 1; iss_addr = 3;
        stepCycle();
        setIdle(); rd_addr_a = 3;
        #1 checkVal("sb_set", 32'(busy_a), 32'h1);
        wr_en_0 = 1; wr_addr_0 = 3; wr_data_0 = 32'hCAFE0003;
        #1 checkVal("sb_fwd", 32'(busy_a), 32'h0);
        stepCycle();
        setIdle(); rd_addr_a = 3;
        #1 checkVal("sb_clr", 32'(busy_a), 32'h0);
        setIdle(); iss_en = 1; iss_addr = 4; wr_en_0 = 1; wr_addr_0 = 4; wr_data_0 = 32'h4;
        stepCycle();
        setIdle(); rd_addr_a = 4;
        #1 checkVal("sb_iss_wins", 32'(busy_a), 32'h1);
        stepCycle();

        // Zero register and flush
        setIdle(); wr_en_0 = 1; wr_addr_0 = 0; wr_data_0 = 32'hFFFFFFFF;
        stepCycle();
        setIdle(); rd_en = 1; rd_addr_a = 0; rd_addr_b = 0;
        stepCycle();
        checkVal("zero_rd", rd_data_a, 32'h0);
        setIdle(); iss_en = 1; iss_addr = 0;
        stepCycle();
        setIdle(); rd_addr_a = 0;
        #1 checkVal("zero_busy", 32'(busy_a), 32'h0);
        setIdle(); iss_en = 1; iss_addr = 1; stepCycle();
        setIdle(); iss_en = 1; iss_addr = 2; stepCycle();
        setIdle(); rd_addr_a = 1; rd_addr_b = 2;
        #1 checkVal("pre_flush_busy", 32'(busy_b), 32'h1);
        setIdle(); flush = 1; iss_en = 1; iss_addr = 6; stepCycle();
        setIdle(); rd_addr_a = 1; rd_addr_b = 6; stepCycle();
        setIdle(); rd_addr_a = 2; rd_addr_b = 4; stepCycle();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            rd_en     = 1'($urandom_range(0, 1));
            rd_addr_a = randAddr();
            rd_addr_b = randAddr();
            wr_en_0   = 1'($urandom_range(0, 1));
            wr_addr_0 = randAddr();
            wr_data_0 = $urandom;
            wr_en_1   = ($urandom_range(0, 2) == 0);
            wr_addr_1 = randAddr();
            wr_data_1 = $urandom;
            iss_en    = 1'($urandom_range(0, 1));
            iss_addr  = randAddr();
            flush     = ($urandom_range(0, 19) == 0);
            stepCycle();
        end

        // Mid-operation reset: outputs clear at once and a concurrent write is lost
        setIdle(); iss_en = 1; iss_addr = 10; stepCycle();
        #2;
        setIdle(); rd_addr_a = 10; rst_n = 1'b0;
        #1;
        checkVal("mid_rst_rd_a", rd_data_a, 32'h0);
        checkVal("mid_rst_rd_b", rd_data_b, 32'h0);
        checkVal("mid_rst_valid", 32'(rd_valid), 32'h0);
        checkVal("mid_rst_busy", 32'(busy_a), 32'h0);
        wr_en_0 = 1; wr_addr_0 = 10; wr_data_0 = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        resetModel();
        setIdle(); rst_n = 1'b1;
        rd_en = 1; rd_addr_a = 10; rd_addr_b = 5;
        stepCycle();
        checkVal("rst_lost_wr", rd_data_a, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end

endmodule
`default_nettype wire
